// File: rtl/spi_deserializer.sv
// spi_deserializer: SPI receive path, MSB-first word assembly.
// Pushes each completed word to the RX FIFO; flags aborts/overruns.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIT_COUNTER_WIDTH
`define BIT_COUNTER_WIDTH $clog2(DATA_WIDTH)
`endif

module spi_deserializer #(
    parameter int DATA_WIDTH        = `DATA_WIDTH,
    parameter int BIT_COUNTER_WIDTH = `BIT_COUNTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    input  logic                  full,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  done,
    output logic                  overrun,
    output logic                  frame_error,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        STORE    = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
        BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;
    logic ss_s1_q, ss_s2_q;
    logic sclk_rise;

    state_t                 state_q, state_d;
    logic [BIT_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q;

    // Two-flop synchronizers plus an edge-detect flop on sclk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= mosi;
            mosi_s2_q   <= mosi_s1_q;
            ss_s1_q     <= ss_n;
            ss_s2_q     <= ss_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;

    // Next-state and registered-output logic for the receive FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ss_s2_q) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = LAST_BIT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s2_q};
                    if (cnt_q == '0) begin
                        state_d = STORE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (ss_s2_q) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end
            end
            STORE: begin
                wdata_d = shift_q;
                we_d    = ~full;
                ovr_d   = full;
                done_d  = 1'b1;
                state_d = COMPLETE;
            end
            COMPLETE: begin
                if (!ss_s2_q) begin
                    state_d = SHIFT;
                    cnt_d   = LAST_BIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign write_en    = we_q;
    assign write_data  = wdata_q;
    assign done        = done_q;
    assign overrun     = ovr_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer: directed checks of the SPI receive path.
// Drives framed serial words and compares strobes and data.
module tb_spi_deserializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          ss_n = 1'b1;
    logic          full = 1'b0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          done;
    logic          overrun;
    logic          frame_error;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    int we_cnt = 0, done_cnt = 0, ov_cnt = 0, fe_cnt = 0;
    int excl_err = 0, b2b_drop = 0, idle_busy = 0;
    logic watch_busy = 1'b0;
    logic watch_idle = 1'b0;
    logic [DW-1:0] dq[$];

    int s_we, s_done, s_ov, s_fe;
    logic [DW-1:0] got_d;

    spi_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss_n       (ss_n),
        .full       (full),
        .write_en   (write_en),
        .write_data (write_data),
        .done       (done),
        .overrun    (overrun),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Event monitor sampling outputs away from the active edge.
    always @(negedge clk) begin
        if (write_en) begin
            we_cnt++;
            dq.push_back(write_data);
        end
        if (done) done_cnt++;
        if (overrun) ov_cnt++;
        if (frame_error) fe_cnt++;
        if (done != (write_en ^ overrun)) excl_err++;
        if (write_en && overrun) excl_err++;
        if (watch_busy && !busy) b2b_drop++;
        if (watch_idle && busy) idle_busy++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_we   = we_cnt;
        s_done = done_cnt;
        s_ov   = ov_cnt;
        s_fe   = fe_cnt;
    endtask

    task automatic pop(output logic [DW-1:0] d);
        if (dq.size() > 0) d = dq.pop_front();
        else d = 'x;
    endtask

    task automatic send_word(input logic [DW-1:0] w,
                             input int nb,
                             input bit fin);
        for (int i = 0; i < nb; i++) begin
            mosi = w[DW-1-i];
            clks(2);
            sclk = 1'b1;
            if (fin && i == nb - 1) begin
                clks(1);
                watch_busy = 1'b0;
                ss_n = 1'b1;
                clks(3);
                sclk = 1'b0;
                clks(6);
            end else begin
                clks(4);
                sclk = 1'b0;
                clks(2);
            end
        end
    endtask

    task automatic open_frame();
        ss_n = 1'b0;
        clks(4);
    endtask

    initial begin
        clks(3);
        check("rst_we", write_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_data", write_data, 0);
        check("rst_ov", overrun, 0);
        check("rst_fe", frame_error, 0);
        rst = 1'b1;
        clks(3);

        snap();
        open_frame();
        send_word(8'hA5, 8, 1);
        check("a5_we", we_cnt - s_we, 1);
        check("a5_done", done_cnt - s_done, 1);
        check("a5_ov", ov_cnt - s_ov, 0);
        check("a5_data", write_data, 8'hA5);
        pop(got_d);
        check("a5_fifo", got_d, 8'hA5);

        snap();
        open_frame();
        watch_busy = 1'b1;
        send_word(8'h3C, 8, 0);
        send_word(8'hC3, 8, 1);
        check("b2b_we", we_cnt - s_we, 2);
        pop(got_d);
        check("b2b_d0", got_d, 8'h3C);
        pop(got_d);
        check("b2b_d1", got_d, 8'hC3);
        check("b2b_fe", fe_cnt - s_fe, 0);
        check("b2b_busy", b2b_drop, 0);

        snap();
        full = 1'b1;
        open_frame();
        send_word(8'hFF, 8, 1);
        full = 1'b0;
        check("ovr_we", we_cnt - s_we, 0);
        check("ovr_ov", ov_cnt - s_ov, 1);
        check("ovr_done", done_cnt - s_done, 1);
        check("ovr_data", write_data, 8'hFF);

        snap();
        open_frame();
        send_word(8'hB7, 5, 0);
        ss_n = 1'b1;
        clks(6);
        check("abt_fe", fe_cnt - s_fe, 1);
        check("abt_we", we_cnt - s_we, 0);
        check("abt_done", done_cnt - s_done, 0);
        check("abt_busy", busy, 0);
        snap();
        open_frame();
        send_word(8'h81, 8, 1);
        check("abt2_we", we_cnt - s_we, 1);
        pop(got_d);
        check("abt2_data", got_d, 8'h81);

        snap();
        open_frame();
        send_word(8'hE4, 4, 0);
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_data", write_data, 0);
        check("mrst_we", write_en, 0);
        ss_n = 1'b1;
        clks(3);
        check("mrst_done", done_cnt - s_done, 0);
        rst = 1'b1;
        clks(3);
        snap();
        open_frame();
        send_word(8'h5A, 8, 1);
        check("post_we", we_cnt - s_we, 1);
        check("post_data", write_data, 8'h5A);
        pop(got_d);
        check("post_fifo", got_d, 8'h5A);

        snap();
        watch_idle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            clks(3);
            sclk = 1'b0;
            clks(3);
        end
        clks(4);
        watch_idle = 1'b0;
        check("idle_busy", idle_busy, 0);
        check("idle_done", done_cnt - s_done, 0);
        check("idle_we", we_cnt - s_we, 0);

        check("excl", excl_err, 0);
        check("fifo_empty", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_deserializer.md
# spi_deserializer

Receive-side counterpart of the SPI serializer. It samples `mosi` on rising `sclk` edges while `ss_n` is low and assembles MSB-first words of `DATA_WIDTH` bits. Each completed word is pushed into the downstream receive FIFO with a one-cycle write strobe. Frame aborts and FIFO overruns are flagged; the word involved is dropped.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8), word size in bits; must be ≥ 2.
- `BIT_COUNTER_WIDTH`, default `` `BIT_COUNTER_WIDTH `` ($clog2(DATA_WIDTH)), width of the bit counter.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, CPOL=0.
- `mosi`  in  1  serial data, MSB first.
- `ss_n`  in  1  frame select, active-low.
- `full`  in  1  receive FIFO full.
- `write_en`  out  1  one-cycle FIFO write strobe.
- `write_data`  out  DATA_WIDTH  received word.
- `done`  out  1  one-cycle pulse per completed word, whether written or dropped.
- `overrun`  out  1  one-cycle pulse: word dropped because `full` was high.
- `frame_error`  out  1  one-cycle pulse: `ss_n` rose mid-word.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Input capture: `sclk`, `mosi` and `ss_n` each pass through a 2-flop synchronizer.
  - Synchronizer reset values: 0, 0, 1.
  - A third flop on synchronized `sclk` gives `sclk_rise` = sync & !prev.
  - The synchronized `mosi` is the sampled bit.
- FSM, 2-bit encoding, states IDLE=0, SHIFT=1, STORE=2, COMPLETE=3:
  - IDLE: when synchronized `ss_n` is 0, go to SHIFT, clear `shift_reg`, set `bit_counter` = DATA_WIDTH-1. `sclk` edges while `ss_n` is high are ignored.
  - SHIFT: on `sclk_rise`, `shift_reg` <= {shift_reg[W-2:0], mosi_s}.
    - If `bit_counter` == 0, go to STORE.
    - Otherwise decrement `bit_counter`.
  - SHIFT abort: synchronized `ss_n` == 1 with no `sclk_rise` in the same cycle. Go to IDLE, pulse `frame_error`, discard the partial word.
  - STORE: lasts exactly 1 cycle, then unconditionally go to COMPLETE.
    - Register `write_data` <= `shift_reg`.
    - Register `write_en` <= !full and `overrun` <= full.
    - `done` <= 1.
  - COMPLETE: lasts exactly 1 cycle. The `write_en`/`overrun` and `done` pulses are visible during this cycle.
    - If synchronized `ss_n` == 0, go to SHIFT and reload `bit_counter` = DATA_WIDTH-1 (back-to-back words).
    - Otherwise go to IDLE.
- All outputs are registered.
- `write_data` holds its value until the next STORE.
- `write_en` and `overrun` are mutually exclusive; exactly one of them accompanies every `done`.
- `ss_n` changes during STORE or COMPLETE do not abort the word; they are evaluated only at the COMPLETE exit.

## Timing
- Reset (`rst`=0), asynchronous: state=IDLE, `bit_counter`=0, `shift_reg`=0.
  - Outputs: `write_en`=0, `write_data`=0, `done`=0, `overrun`=0, `frame_error`=0, `busy`=0.
  - Asserting reset mid-word drops the word with no pulse.
- Latency: the final-bit `sclk` rise at the pin reaches `sclk_rise` after 2 clk edges. The shift and the move to STORE happen at the 3rd edge. `write_en`/`done` are high after the 4th edge, for one cycle.
- Source requirements:
  - Each `sclk` high and low phase is ≥ 2 clk cycles.
  - `mosi` is stable from 1 clk before to 2 clk after the `sclk` rise.
  - `ss_n` falls ≥ 2 clk before the first `sclk` rise.
- Simultaneous `ss_n` rise and final `sclk_rise` in SHIFT: the edge wins. The word completes normally and there is no `frame_error`.
- `full` is sampled only in the STORE cycle. A later change of `full` does not affect that word.
- Minimum word period: DATA_WIDTH sclk periods. FSM overhead is 2 clk, absorbed within the first `sclk` low phase of the next word.

## Test plan
- `ss_n`=0, send 8'hA5, `full`=0 -> `write_en`=1 and `done`=1 in the same single cycle, `write_data`=8'hA5, `overrun`=0.
- Hold `ss_n` low and send 8'h3C then 8'hC3 back-to-back -> two `write_en` pulses in order with data 3C then C3, `frame_error` never asserted, `busy` stays 1 between the words.
- `full`=1 during STORE, send 8'hFF -> `write_en`=0, `overrun`=1 and `done`=1 for one cycle, `write_data`=8'hFF.
- Raise `ss_n` after 5 bits -> one-cycle `frame_error`, no `write_en`, state IDLE. A following full frame of 8'h81 is written correctly.
- Drive `rst`=0 after 4 bits -> all outputs 0 immediately. After release, frame 8'h5A is received with `write_data`=8'h5A.
- Toggle `sclk` 16 times with `ss_n`=1 -> `busy`, `done` and `write_en` stay 0 throughout.
